// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one external combinational ALU.
// IDLE picks a requester and latches its opcode and operands. EXEC captures
// the ALU result. RESP holds that result for the granted requester until
// the requester takes it.
// Arbitration is round-robin by default. Defining ALU_ARB_FIXED_PRIO_EN
// gives requester 0 fixed priority instead.
module alu_arbiter #(
  parameter int WIDTH = 48,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             gnt_q, gnt_d;
  logic             last_grant_q, last_grant_d;
  logic             pick1;
  logic             rsp_take;

  // Arbitration: pick1 is high when requester 1 would be granted this cycle.
  always_comb begin
    pick1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    pick1 = req1_valid & ~req0_valid;
`else
    pick1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif
  end

  // Ready is combinational and only asserted while idle.
  always_comb begin
    req0_ready = (state_q == IDLE) & req0_valid & ~pick1;
    req1_ready = (state_q == IDLE) & pick1;
  end

  // The granted requester's ready condition for leaving RESP.
  always_comb begin
    rsp_take = gnt_q ? rsp1_ready : rsp0_ready;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    zero_d       = zero_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d   = pick1;
          op_d    = pick1 ? req1_op : req0_op;
          a_d     = pick1 ? req1_a  : req0_a;
          b_d     = pick1 ? req1_b  : req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_take) begin
          last_grant_d = gnt_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath flops; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      zero_q       <= zero_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs are decoded purely from flops. The non-granted side reads zero.
  always_comb begin
    alu_op       = op_q;
    alu_operand1 = a_q;
    alu_operand2 = b_q;
    busy         = (state_q != IDLE);
    rsp0_valid   = (state_q == RESP) & ~gnt_q;
    rsp1_valid   = (state_q == RESP) &  gnt_q;
    rsp0_result  = rsp0_valid ? res_q : '0;
    rsp1_result  = rsp1_valid ? res_q : '0;
    rsp0_zero    = rsp0_valid & zero_q;
    rsp1_zero    = rsp1_valid & zero_q;
  end

endmodule
